ctrl_sequencer: RTL and testbench

Hardwired control sequencer for the 32-bit bus datapath (R0–R15, HI, LO, Y, Z, PC, IR, MAR, MDR). It runs the fetch/decode/execute step sequence T0..T7 and drives the datapath's register-in enables, the 5-bit bus-select code into the 32-to-5 encoder/bus mux, the ALU operation, and a Read/Write memory handshake. It sits beside the datapath and replaces the hand-driven simulated control signals with a state machine.

---
 rtl/cpu_ctrl_pkg.sv | 75 +++++++
 rtl/ctrl_sequencer_if.sv | 42 ++++
 rtl/instr_decode.sv | 46 ++++
 rtl/ctrl_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_ctrl_sequencer.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared constants and types for the hardwired control sequencer:
// opcodes, bus-select codes, ALU codes, step states and the decode bundle.
package cpu_ctrl_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned REG_N     = 16;
    localparam int unsigned IDX_W     = 4;
    localparam int unsigned SEL_W     = 5;
    localparam int unsigned OP_W      = 5;
    localparam int unsigned ALU_W     = 5;
    localparam int unsigned FIELD_LSB = 15;

    // Opcodes (ir[31:27])
    localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
    localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
    localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
    localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OP_W-1:0] OP_ADDI = 5'b01000;
    localparam logic [OP_W-1:0] OP_MUL  = 5'b01111;
    localparam logic [OP_W-1:0] OP_DIV  = 5'b10000;
    localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
    localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

    // Bus-select codes; 0..15 select Rn directly
    localparam logic [SEL_W-1:0] SEL_ZHI = 5'd18;
    localparam logic [SEL_W-1:0] SEL_ZLO = 5'd19;
    localparam logic [SEL_W-1:0] SEL_PC  = 5'd20;
    localparam logic [SEL_W-1:0] SEL_MDR = 5'd21;
    localparam logic [SEL_W-1:0] SEL_C   = 5'd23;

    // ALU operation codes
    localparam logic [ALU_W-1:0] ALU_ADD = 5'd0;
    localparam logic [ALU_W-1:0] ALU_SUB = 5'd1;
    localparam logic [ALU_W-1:0] ALU_AND = 5'd2;
    localparam logic [ALU_W-1:0] ALU_OR  = 5'd3;
    localparam logic [ALU_W-1:0] ALU_MUL = 5'd4;
    localparam logic [ALU_W-1:0] ALU_DIV = 5'd5;

    typedef enum logic [3:0] {
        ST_RESET,
        ST_T0,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_T4,
        ST_T5,
        ST_T6,
        ST_T7,
        ST_HALT
    } state_e;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_IMM,
        CLS_LD,
        CLS_ST,
        CLS_MULDIV,
        CLS_NOP,
        CLS_HALT,
        CLS_ILLEGAL
    } instr_class_e;

    typedef struct packed {
        logic [IDX_W-1:0] ra;
        logic [IDX_W-1:0] rb;
        logic [IDX_W-1:0] rc;
        logic [REG_N-1:0] ra_mask;
        instr_class_e     cls;
        logic [ALU_W-1:0] alu_op;
    } decode_t;

endpackage

// File: rtl/ctrl_sequencer_if.sv
// Control bundle between the sequencer (master) and the datapath (slave).
interface ctrl_sequencer_if
    import cpu_ctrl_pkg::*;
();

    logic              run;
    logic [DATA_W-1:0] ir;
    logic              mem_rdy;
    logic [SEL_W-1:0]  bus_sel;
    logic [REG_N-1:0]  r_in;
    logic              pc_in;
    logic              ir_in;
    logic              mar_in;
    logic              mdr_in;
    logic              y_in;
    logic              z_in;
    logic              hi_in;
    logic              lo_in;
    logic              mdr_src;
    logic              inc_pc;
    logic [ALU_W-1:0]  alu_op;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] pc_load_val;
    logic              halted;
    logic              illegal;

    modport master (
        input  run, ir, mem_rdy,
        output bus_sel, r_in, pc_in, ir_in, mar_in, mdr_in, y_in, z_in,
               hi_in, lo_in, mdr_src, inc_pc, alu_op, read, write,
               pc_load_val, halted, illegal
    );

    modport slave (
        output run, ir, mem_rdy,
        input  bus_sel, r_in, pc_in, ir_in, mar_in, mdr_in, y_in, z_in,
               hi_in, lo_in, mdr_src, inc_pc, alu_op, read, write,
               pc_load_val, halted, illegal
    );

endinterface

// File: rtl/instr_decode.sv
// Combinational instruction decode: register fields, one-hot Ra mask and
// opcode class. Macro CTRL_MULDIV_EN makes mul/div legal.
module instr_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [DATA_W-1:FIELD_LSB] ir_f,
    output decode_t                   dec
);

`ifdef CTRL_MULDIV_EN
    localparam instr_class_e MULDIV_CLS = CLS_MULDIV;
`else
    localparam instr_class_e MULDIV_CLS = CLS_ILLEGAL;
`endif

    logic [OP_W-1:0] opcode;

    assign opcode = ir_f[31:27];

    // Field extraction and opcode classification
    always_comb begin
        dec         = '0;
        dec.ra      = ir_f[26:23];
        dec.rb      = ir_f[22:19];
        dec.rc      = ir_f[18:15];
        dec.ra_mask = REG_N'(1) << ir_f[26:23];
        dec.alu_op  = ALU_ADD;
        dec.cls     = CLS_ILLEGAL;
        case (opcode)
            OP_ADD:  dec.cls = CLS_ALU;
            OP_SUB:  begin dec.cls = CLS_ALU; dec.alu_op = ALU_SUB; end
            OP_AND:  begin dec.cls = CLS_ALU; dec.alu_op = ALU_AND; end
            OP_OR:   begin dec.cls = CLS_ALU; dec.alu_op = ALU_OR;  end
            OP_ADDI,
            OP_LDI:  dec.cls = CLS_IMM;
            OP_LD:   dec.cls = CLS_LD;
            OP_ST:   dec.cls = CLS_ST;
            OP_MUL:  begin dec.cls = MULDIV_CLS; dec.alu_op = ALU_MUL; end
            OP_DIV:  begin dec.cls = MULDIV_CLS; dec.alu_op = ALU_DIV; end
            OP_NOP:  dec.cls = CLS_NOP;
            OP_HALT: dec.cls = CLS_HALT;
            default: dec.cls = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// Hardwired fetch/decode/execute sequencer (RESET, T0..T7, HALT) for the
// 32-bit bus datapath. Macro CTRL_MULDIV_EN enables the mul/div sequence.
// Outputs are decoded from the registered step and ir; clr low forces them
// all to zero so every strobe drops the moment reset is applied.
module ctrl_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input logic              clk,
    input logic              clr,
    ctrl_sequencer_if.master cif
);

    state_e  state;
    logic    halted_q;
    logic    illegal_q;
    decode_t dec;

    instr_decode u_decode (
        .ir_f (cif.ir[DATA_W-1:FIELD_LSB]),
        .dec  (dec)
    );

    // Step register and sticky halt/illegal flags
    always_ff @(posedge clk) begin
        if (!clr) begin
            state     <= ST_RESET;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            case (state)
                ST_RESET: state <= ST_T0;
                ST_T0:    if (cif.run) state <= ST_T1;
                ST_T1:    if (cif.mem_rdy) state <= ST_T2;
                ST_T2:    state <= ST_T3;
                ST_T3: begin
                    case (dec.cls)
                        CLS_NOP:     state <= ST_T0;
                        CLS_HALT:    begin state <= ST_HALT; halted_q  <= 1'b1; end
                        CLS_ILLEGAL: begin state <= ST_HALT; illegal_q <= 1'b1; end
                        default:     state <= ST_T4;
                    endcase
                end
                ST_T4:    state <= ST_T5;
                ST_T5: begin
                    case (dec.cls)
                        CLS_LD, CLS_ST, CLS_MULDIV: state <= ST_T6;
                        default:                    state <= ST_T0;
                    endcase
                end
                ST_T6: begin
                    case (dec.cls)
                        CLS_LD:  if (cif.mem_rdy) state <= ST_T7;
                        CLS_ST:  state <= ST_T7;
                        default: state <= ST_T0;
                    endcase
                end
                ST_T7: begin
                    if (dec.cls != CLS_ST || cif.mem_rdy) state <= ST_T0;
                end
                ST_HALT:  state <= ST_HALT;
                default:  state <= ST_RESET;
            endcase
        end
    end

    // Per-step control decode
    always_comb begin
        cif.bus_sel = '0;
        cif.r_in    = '0;
        cif.alu_op  = ALU_ADD;
        cif.pc_in   = 1'b0;
        cif.ir_in   = 1'b0;
        cif.mar_in  = 1'b0;
        cif.mdr_in  = 1'b0;
        cif.y_in    = 1'b0;
        cif.z_in    = 1'b0;
        cif.hi_in   = 1'b0;
        cif.lo_in   = 1'b0;
        cif.mdr_src = 1'b0;
        cif.inc_pc  = 1'b0;
        cif.read    = 1'b0;
        cif.write   = 1'b0;
        if (clr) begin
            case (state)
                ST_RESET: begin
                    cif.bus_sel = SEL_PC;
                    cif.pc_in   = 1'b1;
                end
                ST_T0: begin
                    cif.bus_sel = SEL_PC;
                    cif.mar_in  = 1'b1;
                    cif.inc_pc  = 1'b1;
                    cif.z_in    = 1'b1;
                end
                ST_T1: begin
                    cif.bus_sel = SEL_ZLO;
                    cif.pc_in   = 1'b1;
                    cif.read    = 1'b1;
                    cif.mdr_src = 1'b1;
                    cif.mdr_in  = cif.mem_rdy;
                end
                ST_T2: begin
                    cif.bus_sel = SEL_MDR;
                    cif.ir_in   = 1'b1;
                end
                ST_T3: begin
                    case (dec.cls)
                        CLS_ALU, CLS_IMM, CLS_LD, CLS_ST: begin
                            cif.bus_sel = SEL_W'(dec.rb);
                            cif.y_in    = 1'b1;
                        end
                        CLS_MULDIV: begin
                            cif.bus_sel = SEL_W'(dec.ra);
                            cif.y_in    = 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_T4: begin
                    case (dec.cls)
                        CLS_ALU: begin
                            cif.bus_sel = SEL_W'(dec.rc);
                            cif.alu_op  = dec.alu_op;
                            cif.z_in    = 1'b1;
                        end
                        CLS_IMM, CLS_LD, CLS_ST: begin
                            cif.bus_sel = SEL_C;
                            cif.alu_op  = ALU_ADD;
                            cif.z_in    = 1'b1;
                        end
                        CLS_MULDIV: begin
                            cif.bus_sel = SEL_W'(dec.rb);
                            cif.alu_op  = dec.alu_op;
                            cif.z_in    = 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_T5: begin
                    cif.bus_sel = SEL_ZLO;
                    case (dec.cls)
                        CLS_ALU, CLS_IMM: cif.r_in   = dec.ra_mask;
                        CLS_LD, CLS_ST:   cif.mar_in = 1'b1;
                        CLS_MULDIV:       cif.lo_in  = 1'b1;
                        default:          cif.bus_sel = '0;
                    endcase
                end
                ST_T6: begin
                    case (dec.cls)
                        CLS_LD: begin
                            cif.read    = 1'b1;
                            cif.mdr_src = 1'b1;
                            cif.mdr_in  = cif.mem_rdy;
                        end
                        CLS_ST: begin
                            cif.bus_sel = SEL_W'(dec.ra);
                            cif.mdr_in  = 1'b1;
                        end
                        CLS_MULDIV: begin
                            cif.bus_sel = SEL_ZHI;
                            cif.hi_in   = 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_T7: begin
                    case (dec.cls)
                        CLS_LD: begin
                            cif.bus_sel = SEL_MDR;
                            cif.r_in    = dec.ra_mask;
                        end
                        CLS_ST:  cif.write = 1'b1;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign cif.halted      = halted_q & clr;
    assign cif.illegal     = illegal_q & clr;
    assign cif.pc_load_val = RESET_PC;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer: a step-list reference model expands each
// instruction into the expected per-cycle control word, driven with
// directed cases followed by randomized instructions and memory waits.
module tb_ctrl_sequencer;

    localparam logic [31:0] TB_PC = 32'h0000_0100;

    // Enable bit masks in the order pc,ir,mar,mdr,y,z,hi,lo,mdr_src,inc_pc,read,write
    localparam logic [11:0] M_PC  = 12'h800;
    localparam logic [11:0] M_IR  = 12'h400;
    localparam logic [11:0] M_MAR = 12'h200;
    localparam logic [11:0] M_MDR = 12'h100;
    localparam logic [11:0] M_Y   = 12'h080;
    localparam logic [11:0] M_Z   = 12'h040;
    localparam logic [11:0] M_HI  = 12'h020;
    localparam logic [11:0] M_LO  = 12'h010;
    localparam logic [11:0] M_SRC = 12'h008;
    localparam logic [11:0] M_INC = 12'h004;
    localparam logic [11:0] M_RD  = 12'h002;
    localparam logic [11:0] M_WR  = 12'h001;

    typedef struct {
        logic        c;
        logic        r;
        logic        rdy;
        logic [31:0] ir;
        logic [39:0] exp;
    } step_t;

    logic        clk = 1'b0;
    logic        clr;
    step_t       q[$];
    int          errors = 0;
    int          checks = 0;
    logic        m_halted = 1'b0;
    logic        m_illegal = 1'b0;
    logic [31:0] cur_ir = '0;
    logic [39:0] obs;
    logic [4:0]  ops[$];

    always #5 clk = ~clk;

    ctrl_sequencer_if ifc ();

    ctrl_sequencer #(.RESET_PC(TB_PC)) dut (
        .clk (clk),
        .clr (clr),
        .cif (ifc)
    );

    assign obs = {ifc.bus_sel, ifc.r_in, ifc.alu_op,
                  ifc.pc_in, ifc.ir_in, ifc.mar_in, ifc.mdr_in, ifc.y_in, ifc.z_in,
                  ifc.hi_in, ifc.lo_in, ifc.mdr_src, ifc.inc_pc, ifc.read, ifc.write,
                  ifc.halted, ifc.illegal};

    function automatic logic rnd();
        return 1'($urandom);
    endfunction

    task automatic push(input logic c, input logic r, input logic rdy,
                        input logic [4:0] bs, input logic [15:0] ri,
                        input logic [4:0] op, input logic [11:0] en);
        step_t s;
        s.c   = c;
        s.r   = r;
        s.rdy = rdy;
        s.ir  = cur_ir;
        s.exp = c ? {bs, ri, op, en, m_halted, m_illegal} : 40'd0;
        q.push_back(s);
    endtask

    // Expected cycle list for one instruction: hold = cycles with run low in T0,
    // w1 = fetch wait cycles, wm = wait cycles in the T6 read / T7 write.
    task automatic model_instr(input logic [31:0] ir, input int w1, input int wm, input int hold);
        logic [4:0]  op;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [4:0]  rc;
        logic [15:0] oh;
        op = ir[31:27];
        ra = {1'b0, ir[26:23]};
        rb = {1'b0, ir[22:19]};
        rc = {1'b0, ir[18:15]};
        oh = 16'd1 << ir[26:23];
        cur_ir = ir;
        repeat (hold) push(1, 0, rnd(), 5'd20, 16'd0, 5'd0, M_MAR | M_INC | M_Z);
        push(1, 1, rnd(), 5'd20, 16'd0, 5'd0, M_MAR | M_INC | M_Z);
        repeat (w1) push(1, rnd(), 0, 5'd19, 16'd0, 5'd0, M_PC | M_RD | M_SRC);
        push(1, rnd(), 1, 5'd19, 16'd0, 5'd0, M_PC | M_RD | M_SRC | M_MDR);
        push(1, rnd(), rnd(), 5'd21, 16'd0, 5'd0, M_IR);
        case (op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
                push(1, rnd(), rnd(), rb, 16'd0, 5'd0, M_Y);
                push(1, rnd(), rnd(), rc, 16'd0, 5'(op - 5'd3), M_Z);
                push(1, rnd(), rnd(), 5'd19, oh, 5'd0, 12'd0);
            end
            5'b01000, 5'b00001: begin
                push(1, rnd(), rnd(), rb, 16'd0, 5'd0, M_Y);
                push(1, rnd(), rnd(), 5'd23, 16'd0, 5'd0, M_Z);
                push(1, rnd(), rnd(), 5'd19, oh, 5'd0, 12'd0);
            end
            5'b00000: begin
                push(1, rnd(), rnd(), rb, 16'd0, 5'd0, M_Y);
                push(1, rnd(), rnd(), 5'd23, 16'd0, 5'd0, M_Z);
                push(1, rnd(), rnd(), 5'd19, 16'd0, 5'd0, M_MAR);
                repeat (wm) push(1, rnd(), 0, 5'd0, 16'd0, 5'd0, M_RD | M_SRC);
                push(1, rnd(), 1, 5'd0, 16'd0, 5'd0, M_RD | M_SRC | M_MDR);
                push(1, rnd(), rnd(), 5'd21, oh, 5'd0, 12'd0);
            end
            5'b00010: begin
                push(1, rnd(), rnd(), rb, 16'd0, 5'd0, M_Y);
                push(1, rnd(), rnd(), 5'd23, 16'd0, 5'd0, M_Z);
                push(1, rnd(), rnd(), 5'd19, 16'd0, 5'd0, M_MAR);
                push(1, rnd(), rnd(), ra, 16'd0, 5'd0, M_MDR);
                repeat (wm) push(1, rnd(), 0, 5'd0, 16'd0, 5'd0, M_WR);
                push(1, rnd(), 1, 5'd0, 16'd0, 5'd0, M_WR);
            end
            5'b11010: push(1, rnd(), rnd(), 5'd0, 16'd0, 5'd0, 12'd0);
            5'b11011: begin
                push(1, rnd(), rnd(), 5'd0, 16'd0, 5'd0, 12'd0);
                m_halted = 1'b1;
            end
`ifdef CTRL_MULDIV_EN
            5'b01111, 5'b10000: begin
                push(1, rnd(), rnd(), ra, 16'd0, 5'd0, M_Y);
                push(1, rnd(), rnd(), rb, 16'd0, (op == 5'b01111) ? 5'd4 : 5'd5, M_Z);
                push(1, rnd(), rnd(), 5'd19, 16'd0, 5'd0, M_LO);
                push(1, rnd(), rnd(), 5'd18, 16'd0, 5'd0, M_HI);
            end
`endif
            default: begin
                push(1, rnd(), rnd(), 5'd0, 16'd0, 5'd0, 12'd0);
                m_illegal = 1'b1;
            end
        endcase
    endtask

    task automatic model_halt(input int n);
        repeat (n) push(1, rnd(), rnd(), 5'd0, 16'd0, 5'd0, 12'd0);
    endtask

    // k cycles of clr low, then the RESET step that loads PC
    task automatic model_reset(input int k);
        m_halted  = 1'b0;
        m_illegal = 1'b0;
        repeat (k) push(0, rnd(), rnd(), 5'd0, 16'd0, 5'd0, 12'd0);
        push(1, 1, rnd(), 5'd20, 16'd0, 5'd0, M_PC);
    endtask

    task automatic run_q();
        step_t s;
        while (q.size() > 0) begin
            s = q.pop_front();
            clr         = s.c;
            ifc.run     = s.r;
            ifc.mem_rdy = s.rdy;
            ifc.ir      = s.ir;
            @(negedge clk);
            checks++;
            assert (obs === s.exp) else begin
                errors++;
                $error("FAIL step%0d ir=%h observed=%h expected=%h", checks, ifc.ir, obs, s.exp);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [31:0] rir;
        logic [4:0]  rop;
        clr         = 1'b0;
        ifc.run     = 1'b0;
        ifc.mem_rdy = 1'b0;
        ifc.ir      = '0;
        ops = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b01000, 5'b00001,
                5'b00000, 5'b00010, 5'b11010, 5'b11011, 5'b10101};
`ifdef CTRL_MULDIV_EN
        ops.push_back(5'b01111);
        ops.push_back(5'b10000);
`endif

        // Reset, then a zero-wait add R5,R2,R4
        model_reset(3);
        run_q();
        checks++;
        assert (ifc.pc_load_val === TB_PC) else begin
            errors++;
            $error("FAIL pc_load_val observed=%h expected=%h", ifc.pc_load_val, TB_PC);
        end
        model_instr(32'h1A92_0000, 0, 0, 0);
        run_q();

        // ld R1,0x55(R3) with three read wait cycles in T6
        model_instr(32'h0098_0055, 0, 3, 0);
        run_q();

        // st R7,0x10(R0), clr applied during the T7 write wait
        model_instr(32'h1380_0010, 1, 4, 0);
        void'(q.pop_back());
        model_reset(2);
        run_q();

        // mul R1,R2: illegal without the option, full sequence with it
        model_instr(32'h7890_0000, 0, 0, 1);
        if (m_illegal) begin
            model_halt(20);
            model_reset(2);
        end
        run_q();

        // halt, then a clr pulse and refetch
        model_instr(32'hD800_0000, 2, 0, 0);
        model_halt(5);
        model_reset(1);
        run_q();

        // Randomized instruction stream
        for (int i = 0; i < 60; i++) begin
            rop = ops[$urandom_range(0, ops.size() - 1)];
            rir = {rop, 27'($urandom)};
            model_instr(rir, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            if (m_halted || m_illegal) begin
                model_halt($urandom_range(1, 4));
                model_reset($urandom_range(1, 2));
            end
            run_q();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
